// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC3 latency memory.
package lc3_mem_pkg;

   localparam int DATA_W = 16;

   // Fibonacci feedback taps 16,14,13,11 (bits 15,13,12,10).
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } port_state_e;

   // Width needed to hold a latency value in 0..max(a,b).
   function automatic int lat_cnt_w(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/lc3_mem_port.sv
// One access port: IDLE/WAIT/DONE FSM, latency down-counter and request latch.
// The array lives in the parent; this block tells it when and where to write
// and captures read data on the WAIT->DONE edge.
//
// state | meaning
// IDLE  | no access; accept request and load latency counter
// WAIT  | counting down; abort if request drops or address/rd changes
// DONE  | complete_o high, dout_o held while request and address persist
module lc3_mem_port
   import lc3_mem_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              rd_i,
   input  logic [DATA_W-1:0] din_i,
   input  logic [CNT_W-1:0]  lat_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              wr_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              complete_o,
   output logic [DATA_W-1:0] dout_o
);

   port_state_e       state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic              rd_q;
   logic [DATA_W-1:0] din_q;
   logic              complete_q;
   logic [DATA_W-1:0] dout_q;

   logic abort;
   logic fire;

   // Access happens on the edge leaving WAIT; reset suppresses it.
   assign abort = !req_i || (addr_i != addr_q) || (rd_i != rd_q);
   assign fire  = (state_q == WAIT) && !abort && (cnt_q == '0) && !reset;

   assign addr_o     = addr_q;
   assign wr_o       = fire && !rd_q;
   assign wdata_o    = din_q;
   assign complete_o = complete_q;
   assign dout_o     = dout_q;

   // Port FSM with registered completion and read data.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         rd_q       <= 1'b1;
         din_q      <= '0;
         complete_q <= 1'b0;
         dout_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               complete_q <= 1'b0;
               if (req_i) begin
                  addr_q  <= addr_i;
                  rd_q    <= rd_i;
                  din_q   <= din_i;
                  cnt_q   <= lat_i;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (abort) begin
                  state_q <= IDLE;
               end else if (cnt_q == '0) begin
                  state_q    <= DONE;
                  complete_q <= 1'b1;
                  if (rd_q) dout_q <= rdata_i;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DONE: begin
               if (!req_i || (addr_i != addr_q)) begin
                  state_q    <= IDLE;
                  complete_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= IDLE;
               complete_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/lc3_lat_mem.sv
// LC3 dual-port memory with per-access wait cycles.
// Define LC3_MEM_RAND_LAT_EN for LFSR-driven random latencies; otherwise
// latencies are fixed at T_FETCH_MAX / T_DATA_MAX.
module lc3_lat_mem
   import lc3_mem_pkg::*;
#(
   parameter int          ADDR_W      = 16,
   parameter int          T_FETCH_MAX = 10,
   parameter int          T_DATA_MAX  = 10,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] pc,
   input  logic        instrmem_rd,
   output logic [15:0] Instr_dout,
   output logic        complete_instr,
   input  logic        data_req,
   input  logic [15:0] Data_addr,
   input  logic        Data_rd,
   input  logic [15:0] Data_din,
   output logic [15:0] Data_dout,
   output logic        complete_data,
   input  logic        ld_en,
   input  logic [15:0] ld_addr,
   input  logic [15:0] ld_data
);

   localparam int CNT_W = lat_cnt_w(T_FETCH_MAX, T_DATA_MAX);

   logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

   logic [CNT_W-1:0]  instr_lat, data_lat;
   logic [ADDR_W-1:0] instr_addr, data_addr;
   logic              instr_wr, data_wr;
   logic [DATA_W-1:0] instr_wdata, data_wdata;
   logic [DATA_W-1:0] instr_rdata, data_rdata;

`ifdef LC3_MEM_RAND_LAT_EN
   localparam logic [7:0] F_MOD = 8'(T_FETCH_MAX + 1);
   localparam logic [7:0] D_MOD = 8'(T_DATA_MAX + 1);

   logic [15:0] lfsr_q;

   // Free-running LFSR; each port samples its slice when it accepts.
   always_ff @(posedge clock) begin
      if (reset) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   end

   assign instr_lat = CNT_W'(lfsr_q[7:0] % F_MOD);
   assign data_lat  = CNT_W'(lfsr_q[15:8] % D_MOD);
`else
   logic [15:0] unused_seed;
   assign unused_seed = LFSR_SEED;
   assign instr_lat   = CNT_W'(T_FETCH_MAX);
   assign data_lat    = CNT_W'(T_DATA_MAX);
`endif

   // Asynchronous reads; captured by each port on its access edge, so a
   // same-edge data write is seen by the fetch as the old value.
   assign instr_rdata = mem_q[instr_addr];
   assign data_rdata  = mem_q[data_addr];

   // Array writes; backdoor load is last so it wins on an address clash.
   always_ff @(posedge clock) begin
      if (data_wr) mem_q[data_addr] <= data_wdata;
      if (ld_en)   mem_q[ld_addr[ADDR_W-1:0]] <= ld_data;
   end

   lc3_mem_port #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_instr_port (
      .clock      (clock),
      .reset      (reset),
      .req_i      (instrmem_rd),
      .addr_i     (pc[ADDR_W-1:0]),
      .rd_i       (1'b1),
      .din_i      ('0),
      .lat_i      (instr_lat),
      .rdata_i    (instr_rdata),
      .addr_o     (instr_addr),
      .wr_o       (instr_wr),
      .wdata_o    (instr_wdata),
      .complete_o (complete_instr),
      .dout_o     (Instr_dout)
   );

   lc3_mem_port #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_data_port (
      .clock      (clock),
      .reset      (reset),
      .req_i      (data_req),
      .addr_i     (Data_addr[ADDR_W-1:0]),
      .rd_i       (Data_rd),
      .din_i      (Data_din),
      .lat_i      (data_lat),
      .rdata_i    (data_rdata),
      .addr_o     (data_addr),
      .wr_o       (data_wr),
      .wdata_o    (data_wdata),
      .complete_o (complete_data),
      .dout_o     (Data_dout)
   );

   // The instruction port never writes.
   logic unused_instr;
   assign unused_instr = ^{instr_wr, instr_wdata};

endmodule

// File: tb/tb_lc3_lat_mem.sv
// Directed bench for lc3_lat_mem (fixed latency 4/2), or a latency-range
// sweep when LC3_MEM_RAND_LAT_EN is defined.
module tb_lc3_lat_mem;

`ifdef LC3_MEM_RAND_LAT_EN
   localparam int TF = 10;
   localparam int TD = 10;
`else
   localparam int TF = 4;
   localparam int TD = 2;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] pc;
   logic        instrmem_rd;
   logic [15:0] Instr_dout;
   logic        complete_instr;
   logic        data_req;
   logic [15:0] Data_addr;
   logic        Data_rd;
   logic [15:0] Data_din;
   logic [15:0] Data_dout;
   logic        complete_data;
   logic        ld_en;
   logic [15:0] ld_addr;
   logic [15:0] ld_data;

   int checks = 0;
   int errors = 0;

   lc3_lat_mem #(.ADDR_W(16), .T_FETCH_MAX(TF), .T_DATA_MAX(TD), .LFSR_SEED(16'hACE1)) dut (
      .clock          (clock),
      .reset          (reset),
      .pc             (pc),
      .instrmem_rd    (instrmem_rd),
      .Instr_dout     (Instr_dout),
      .complete_instr (complete_instr),
      .data_req       (data_req),
      .Data_addr      (Data_addr),
      .Data_rd        (Data_rd),
      .Data_din       (Data_din),
      .Data_dout      (Data_dout),
      .complete_data  (complete_data),
      .ld_en          (ld_en),
      .ld_addr        (ld_addr),
      .ld_data        (ld_data)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      reset       = 1'b1;
      pc          = 16'd3000;
      instrmem_rd = 1'b1;
      data_req    = 1'b0;
      Data_addr   = 16'd0;
      Data_rd     = 1'b1;
      Data_din    = 16'h0000;
      ld_en       = 1'b1;
      ld_addr     = 16'd3000;
      ld_data     = 16'h1234;

`ifndef LC3_MEM_RAND_LAT_EN
      // Reset held 3 cycles with a fetch request; backdoor loads meanwhile.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("rst_cinstr", complete_instr, 1'b0);
         chk1("rst_cdata", complete_data, 1'b0);
         chk("rst_idout", Instr_dout, 16'h0000);
         chk("rst_ddout", Data_dout, 16'h0000);
         if (i == 0) begin ld_addr = 16'd3001; ld_data = 16'h4321; end
         if (i == 1) ld_en = 1'b0;
      end
      reset = 1'b0;

      // Fetch 3000: accepted at first edge, complete after the 6th (L=4).
      for (int i = 0; i < 5; i++) begin
         tick();
         chk1("fetch_wait", complete_instr, 1'b0);
      end
      tick();
      chk1("fetch_done", complete_instr, 1'b1);
      chk("fetch_data", Instr_dout, 16'h1234);

      // Stall: request held in DONE.
      for (int i = 0; i < 6; i++) begin
         tick();
         chk1("stall_c", complete_instr, 1'b1);
         chk("stall_d", Instr_dout, 16'h1234);
      end
      instrmem_rd = 1'b0;
      tick();
      chk1("drop_c", complete_instr, 1'b0);
      chk("drop_hold_d", Instr_dout, 16'h1234);

      // Data write 3100 <= BEEF (L=2).
      Data_addr = 16'd3100; Data_din = 16'hBEEF; Data_rd = 1'b0; data_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("wr_wait", complete_data, 1'b0);
         chk("wr_dout_wait", Data_dout, 16'h0000);
      end
      tick();
      chk1("wr_done", complete_data, 1'b1);
      chk("wr_dout_keep", Data_dout, 16'h0000);
      data_req = 1'b0;
      tick();
      chk1("wr_drop", complete_data, 1'b0);

      // Read 3100 back.
      Data_rd = 1'b1; data_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("rd_wait", complete_data, 1'b0);
      end
      tick();
      chk1("rd_done", complete_data, 1'b1);
      chk("rd_data", Data_dout, 16'hBEEF);
      data_req = 1'b0;
      tick();

      // Abort: pc 3000 -> 3001 during WAIT.
      pc = 16'd3000; instrmem_rd = 1'b1;
      tick();
      chk1("abort_w0", complete_instr, 1'b0);
      tick();
      chk1("abort_w1", complete_instr, 1'b0);
      pc = 16'd3001;
      tick();
      chk1("abort_edge", complete_instr, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk1("reacc_wait", complete_instr, 1'b0);
      end
      tick();
      chk1("reacc_done", complete_instr, 1'b1);
      chk("reacc_data", Instr_dout, 16'h4321);
      instrmem_rd = 1'b0;
      tick();

      // Same-edge fetch of 3000 and data write 5555 to 3000.
      pc = 16'd3000; instrmem_rd = 1'b1;
      tick();
      tick();
      Data_addr = 16'd3000; Data_din = 16'h5555; Data_rd = 1'b0; data_req = 1'b1;
      tick();
      tick();
      tick();
      chk1("coll_pre_i", complete_instr, 1'b0);
      chk1("coll_pre_d", complete_data, 1'b0);
      tick();
      chk1("coll_ci", complete_instr, 1'b1);
      chk1("coll_cd", complete_data, 1'b1);
      chk("coll_old", Instr_dout, 16'h1234);
      instrmem_rd = 1'b0; data_req = 1'b0;
      tick();
      instrmem_rd = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk1("coll_new_c", complete_instr, 1'b1);
      chk("coll_new", Instr_dout, 16'h5555);
      instrmem_rd = 1'b0;
      tick();

      // ld_en and data write to 3000 on the same edge: ld wins.
      Data_addr = 16'd3000; Data_din = 16'h5555; Data_rd = 1'b0; data_req = 1'b1;
      tick();
      tick();
      tick();
      ld_en = 1'b1; ld_addr = 16'd3000; ld_data = 16'hAAAA;
      tick();
      chk1("ld_coll_cd", complete_data, 1'b1);
      ld_en = 1'b0; data_req = 1'b0;
      tick();
      Data_rd = 1'b1; data_req = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk1("ld_rd_c", complete_data, 1'b1);
      chk("ld_rd_data", Data_dout, 16'hAAAA);
      data_req = 1'b0;
      tick();

      // Reset on the edge where a write to 3100 would happen.
      Data_addr = 16'd3100; Data_din = 16'hDEAD; Data_rd = 1'b0; data_req = 1'b1;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk1("rst_mid_c", complete_data, 1'b0);
      chk("rst_mid_d", Data_dout, 16'h0000);
      reset = 1'b0; data_req = 1'b0;
      tick();
      Data_rd = 1'b1; data_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("rst_rd_wait", complete_data, 1'b0);
      end
      tick();
      chk1("rst_rd_c", complete_data, 1'b1);
      chk("rst_rd_data", Data_dout, 16'hBEEF);
      data_req = 1'b0;
      tick();
`else
      begin
         int seen [0:10];
         int n;
         int lat;
         for (int l = 0; l <= 10; l++) seen[l] = 0;
         ld_en = 1'b0;
         instrmem_rd = 1'b0;
         tick();
         tick();
         reset = 1'b0;
         for (int a = 0; a < 2000; a++) begin
            pc = 16'($urandom);
            instrmem_rd = 1'b1;
            n = 0;
            do begin
               tick();
               n++;
            end while (!complete_instr && n < 20);
            chk1("rand_done", complete_instr, 1'b1);
            lat = n - 2;
            chk1("rand_lat_range", (lat >= 0) && (lat <= TF), 1'b1);
            if (lat >= 0 && lat <= 10) seen[lat]++;
            instrmem_rd = 1'b0;
            tick();
         end
         for (int l = 0; l <= 10; l++)
            chk1("rand_lat_seen", seen[l] != 0, 1'b1);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lc3_lat_mem.md
# lc3_lat_mem

Synthesizable dual-port LC3 memory with per-access latency. It sits directly downstream of the LC3 core: it consumes the instruction-fetch request (pc, instrmem_rd) and the data request (Data_addr, Data_din, Data_rd). It returns Instr_dout/complete_instr and Data_dout/complete_data after a programmable number of wait cycles, so the controller's stall paths are exercised in RTL rather than only by the bench driver.

## Interface
- ADDR_W, 16: word-address width; array depth 2^ADDR_W × 16 bit
- T_FETCH_MAX, 10: instruction-port latency (fixed) or upper bound (random)
- T_DATA_MAX, 10: data-port latency (fixed) or upper bound (random)
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- pc  in  16  instruction address
- instrmem_rd  in  1  instruction read request
- Instr_dout  out  16  fetched instruction
- complete_instr  out  1  instruction access done
- data_req  in  1  data access request (driven by integration from controller mem_state)
- Data_addr  in  16  data address
- Data_rd  in  1  1 = read, 0 = write
- Data_din  in  16  write data
- Data_dout  out  16  read data
- complete_data  out  1  data access done
- ld_en  in  1  backdoor load strobe
- ld_addr  in  16  backdoor load address
- ld_data  in  16  backdoor load data

## Operation
- Two independent port FSMs: IDLE → WAIT → DONE.
- IDLE: request high (instrmem_rd / data_req) → latch address, Data_rd and Data_din; load counter with latency L; go to WAIT.
- WAIT:
  - Counter == 0 → perform access, go to DONE.
  - Otherwise decrement.
  - Request dropped or address/Data_rd changed → abort to IDLE, no array write.
- DONE:
  - complete_* = 1, data output held.
  - Stays while request high and address unchanged, which absorbs pipeline stalls.
  - Otherwise → IDLE; complete_* drops the next cycle.
- Read: dout registered from array[addr] on the WAIT→DONE edge.
- Write (Data_rd = 0): array[addr] ← latched Data_din on the WAIT→DONE edge; Data_dout keeps its previous value.
- Same-edge conflicts:
  - Instruction read vs. data write to the same address: the read returns the old value.
  - ld_en vs. data write to the same address: ld_data wins.
- ld_en writes the array on any cycle, regardless of FSM state.
- Addresses are truncated to ADDR_W bits, so upper bits alias.
- Reset:
  - FSMs go to IDLE.
  - complete_instr, complete_data = 0.
  - Instr_dout, Data_dout = 16'h0000.
  - LFSR = LFSR_SEED.
  - Array contents are not cleared.
- Reset mid-access aborts the access; no write is performed.

## Timing
- Request sampled high in IDLE at edge k → complete_* high from cycle k+1+L, data valid in the same cycle.
- L = 0 gives a 1-cycle access.
- After the request drops or the address changes in DONE: complete_* low 1 cycle later; the new request is accepted 1 cycle after that. Back-to-back access period = L+3 cycles.
- The two ports never stall each other.

## Configuration
- LC3_MEM_RAND_LAT_EN defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle out of reset.
  - Instruction L = lfsr[7:0] % (T_FETCH_MAX+1).
  - Data L = lfsr[15:8] % (T_DATA_MAX+1).
  - Both sampled at acceptance.
- Undefined: L = T_FETCH_MAX / T_DATA_MAX fixed; the LFSR and LFSR_SEED are unused.

## Structure
- Package lc3_mem_pkg holds:
  - port state enum {IDLE, WAIT, DONE}
  - LFSR tap mask
  - data width 16
  - latency counter width (clog2 of max(T_FETCH_MAX, T_DATA_MAX)+1)
- Sub-module lc3_mem_port: one FSM, latency counter and address/control latch. Instantiated twice, for instruction (read-only) and data.
- Top level owns the array, the LFSR, the backdoor and the write arbitration.

## Test plan
- Reset held 3 cycles with instrmem_rd = 1 → complete_* = 0 and douts = 0 throughout. After release, fixed T_FETCH_MAX = 4 with ld-loaded array[3000] = 16'h1234 → complete_instr and Instr_dout = 16'h1234 in the 5th cycle after acceptance.
- Data write: Data_addr = 3100, Data_din = 16'hBEEF, Data_rd = 0, T_DATA_MAX = 2 → complete_data in cycle 3. A following read of 3100 returns 16'hBEEF; Data_dout is unchanged during the write.
- Abort: pc changes from 3000 to 3001 in WAIT → no completion for 3000. 3001 completes L+1 cycles after re-acceptance.
- Stall hold: request held 6 cycles in DONE → complete_instr stays high with a stable value. Request dropped → complete low next cycle.
- Same-edge collision: data write of 16'h5555 to address 3000 while an instruction fetch of 3000 (old value 16'h1234) completes on the same edge → Instr_dout = 16'h1234, a later fetch returns 16'h5555. ld_en with 16'hAAAA on the same edge as a data write of 16'h5555 to 3000 → array = 16'hAAAA.
- With LC3_MEM_RAND_LAT_EN, T_*_MAX = 10, 2000 accesses → every latency in 0..10 is observed and none exceeds 10. Same seed gives an identical latency sequence across runs.
